// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch sequencer sitting in front of a 1-cycle synchronous ROM.
//   The address driven on pc_out in cycle t returns on rom_inst in cycle t+1.
//   Issues one instruction per cycle, resolves JMP / taken BRC redirects
//   locally (one bubble to squash the wrong-path word), and supports stall,
//   start and a programmable end address.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        IDLE -> RUN, or DONE -> IDLE; ignored in RUN/FILL
//   stall        downstream not ready; hold the currently issued instruction
//   branch_flag  branch condition, sampled while a BRC is issued
//   rom_inst     instruction word returned by the ROM
//   pc_out       address presented to the ROM
//   inst_out     issued instruction (straight from rom_inst)
//   inst_valid   inst_out is a valid issued instruction
//   inst_pc      address of inst_out
//   redirect     one-cycle pulse when a JMP / taken BRC is accepted
//   done         high while the run has finished
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [7:0] START_PC = 8'd0,
    parameter logic [7:0] END_PC   = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       branch_flag,
    input  logic [8:0] rom_inst,
    output logic [7:0] pc_out,
    output logic [8:0] inst_out,
    output logic       inst_valid,
    output logic [7:0] inst_pc,
    output logic       redirect,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, FILL, DONE} state_t;

    state_t     state;
    logic [7:0] fetch_pc;   // address currently being read from the ROM
    logic [7:0] issue_pc;   // address of the word now on rom_inst

    logic       is_jmp;
    logic       is_brc;
    logic       take;
    logic       redirect_now;
    logic [7:0] target;

    // Decode of the word being issued this cycle.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        is_jmp = (rom_inst[8:6] == 3'b111);
        is_brc = (rom_inst[8:3] == 6'b010101);
        target = issue_pc + 8'd1 + {5'd0, rom_inst[2:0]};
        if (is_jmp) begin
            target = {rom_inst[5:0], 2'b00};
        end
        take         = is_jmp || (is_brc && branch_flag);
        // Stall wins, and a branch sitting at END_PC is never taken.
        redirect_now = (state == RUN) && !stall && (issue_pc != END_PC) && take;
    end

    // Reset forces the visible outputs idle in the same cycle it is raised,
    // not only after the next edge.
    always_comb begin
        inst_out   = rom_inst;
        inst_pc    = issue_pc;
        inst_valid = !reset && (state == RUN);
        done       = !reset && (state == DONE);
        redirect   = !reset && redirect_now;
        // Under stall the ROM re-reads the issued address so inst_out stays put.
        if (reset) begin
            pc_out = START_PC;
        end else if (state == RUN && stall) begin
            pc_out = issue_pc;
        end else begin
            pc_out = fetch_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= START_PC;
            issue_pc <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Hold START_PC on the ROM so the first word is preloaded.
                    fetch_pc <= START_PC;
                    if (start) begin
                        state    <= RUN;
                        issue_pc <= START_PC;
                        fetch_pc <= START_PC + 8'd1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (issue_pc == END_PC) begin
                            state <= DONE;
                        end else if (take) begin
                            fetch_pc <= target;
                            state    <= FILL;
                        end else begin
                            issue_pc <= fetch_pc;
                            fetch_pc <= fetch_pc + 8'd1;
                        end
                    end
                end
                FILL: begin
                    // rom_inst holds the squashed wrong-path word; the target
                    // is already being read, so resume issuing next cycle.
                    state    <= RUN;
                    issue_pc <= fetch_pc;
                    fetch_pc <= fetch_pc + 8'd1;
                end
                DONE: begin
                    if (start) begin
                        fetch_pc <= START_PC;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] B_END = 8'd12;

    // Instance A: default END_PC (255). Instance B: END_PC = 12.
    logic       a_reset, a_start, a_stall, a_flag;
    logic [8:0] a_rom;
    logic [7:0] a_pc_out, a_inst_pc;
    logic [8:0] a_inst_out;
    logic       a_valid, a_redirect, a_done;

    logic       b_reset, b_start, b_stall, b_flag;
    logic [8:0] b_rom;
    logic [7:0] b_pc_out, b_inst_pc;
    logic [8:0] b_inst_out;
    logic       b_valid, b_redirect, b_done;

    logic [8:0] mem_a [256];
    logic [8:0] mem_b [256];

    fetch_unit dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .stall(a_stall),
        .branch_flag(a_flag), .rom_inst(a_rom), .pc_out(a_pc_out),
        .inst_out(a_inst_out), .inst_valid(a_valid), .inst_pc(a_inst_pc),
        .redirect(a_redirect), .done(a_done)
    );

    fetch_unit #(.START_PC(8'd0), .END_PC(B_END)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .stall(b_stall),
        .branch_flag(b_flag), .rom_inst(b_rom), .pc_out(b_pc_out),
        .inst_out(b_inst_out), .inst_valid(b_valid), .inst_pc(b_inst_pc),
        .redirect(b_redirect), .done(b_done)
    );

    // Synchronous ROMs, one cycle of read latency.
    always @(posedge clk) a_rom <= mem_a[a_pc_out];
    always @(posedge clk) b_rom <= mem_b[b_pc_out];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input logic [7:0] pc);
        int n = 0;
        while (!(a_valid === 1'b1 && a_inst_pc === pc) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (!(a_valid === 1'b1 && a_inst_pc === pc)) begin
            errors++;
            $display("FAIL wait_a: inst_pc=%0d valid=%b, required inst_pc=%0d within 300 cycles",
                     a_inst_pc, a_valid, pc);
        end
    endtask

    task automatic wait_b(input logic [7:0] pc);
        int n = 0;
        while (!(b_valid === 1'b1 && b_inst_pc === pc) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (!(b_valid === 1'b1 && b_inst_pc === pc)) begin
            errors++;
            $display("FAIL wait_b: inst_pc=%0d valid=%b, required inst_pc=%0d within 300 cycles",
                     b_inst_pc, b_valid, pc);
        end
    endtask

    // ---------------------------------------------------------------- A tests
    task automatic test_reset();
        a_reset = 1'b1; a_start = 1'b0; a_stall = 1'b0; a_flag = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_valid, a_redirect, a_done, a_pc_out} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_during: {valid,redirect,done,pc_out}=%h required %h",
                     {a_valid, a_redirect, a_done, a_pc_out}, {1'b0, 1'b0, 1'b0, 8'd0});
        end
        a_reset = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_done, a_pc_out, a_inst_pc} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_idle: {valid,done,pc_out,inst_pc}=%h required %h",
                     {a_valid, a_done, a_pc_out, a_inst_pc}, {1'b0, 1'b0, 8'd0, 8'd0});
        end
    endtask

    task automatic test_sequential();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_inst_pc, a_inst_out, a_pc_out} !== {1'b1, 8'd0, 9'h093, 8'd1}) begin
            errors++;
            $display("FAIL first_issue: {valid,inst_pc,inst_out,pc_out}=%h required %h",
                     {a_valid, a_inst_pc, a_inst_out, a_pc_out}, {1'b1, 8'd0, 9'h093, 8'd1});
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({a_valid, a_inst_pc, a_inst_out, a_pc_out} !== {1'b1, 8'(i), mem_a[i], 8'(i + 1)}) begin
                errors++;
                $display("FAIL sequential_%0d: {valid,inst_pc,inst_out,pc_out}=%h required %h", i,
                         {a_valid, a_inst_pc, a_inst_out, a_pc_out}, {1'b1, 8'(i), mem_a[i], 8'(i + 1)});
            end
        end
    endtask

    task automatic test_stall();
        wait_a(8'd5);
        a_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({a_valid, a_redirect, a_inst_pc, a_inst_out, a_pc_out} !==
                {1'b1, 1'b0, 8'd5, 9'h0B9, 8'd5}) begin
                errors++;
                $display("FAIL stall_hold_%0d: {valid,redirect,inst_pc,inst_out,pc_out}=%h required %h", k,
                         {a_valid, a_redirect, a_inst_pc, a_inst_out, a_pc_out},
                         {1'b1, 1'b0, 8'd5, 9'h0B9, 8'd5});
            end
            tick();
        end
        a_stall = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_inst_pc, a_inst_out, a_pc_out} !== {1'b1, 8'd5, 9'h0B9, 8'd6}) begin
            errors++;
            $display("FAIL stall_release: {valid,inst_pc,inst_out,pc_out}=%h required %h",
                     {a_valid, a_inst_pc, a_inst_out, a_pc_out}, {1'b1, 8'd5, 9'h0B9, 8'd6});
        end
        tick();
        checks++;
        if ({a_valid, a_inst_pc} !== {1'b1, 8'd6}) begin
            errors++;
            $display("FAIL stall_no_bubble: {valid,inst_pc}=%h required %h",
                     {a_valid, a_inst_pc}, {1'b1, 8'd6});
        end
    endtask

    task automatic test_brc_not_taken();
        a_flag = 1'b0;
        wait_a(8'd16);
        checks++;
        if ({a_redirect, a_inst_out} !== {1'b0, 9'h0A9}) begin
            errors++;
            $display("FAIL brc_nt_issue: {redirect,inst_out}=%h required %h",
                     {a_redirect, a_inst_out}, {1'b0, 9'h0A9});
        end
        tick();
        checks++;
        if ({a_valid, a_redirect, a_inst_pc} !== {1'b1, 1'b0, 8'd17}) begin
            errors++;
            $display("FAIL brc_nt_next: {valid,redirect,inst_pc}=%h required %h",
                     {a_valid, a_redirect, a_inst_pc}, {1'b1, 1'b0, 8'd17});
        end
    endtask

    task automatic test_jmp();
        wait_a(8'd19);
        checks++;
        if ({a_redirect, a_inst_out} !== {1'b1, 9'h1CA}) begin
            errors++;
            $display("FAIL jmp_issue: {redirect,inst_out}=%h required %h",
                     {a_redirect, a_inst_out}, {1'b1, 9'h1CA});
        end
        tick();
        checks++;
        if ({a_valid, a_redirect, a_pc_out} !== {1'b0, 1'b0, 8'd40}) begin
            errors++;
            $display("FAIL jmp_bubble: {valid,redirect,pc_out}=%h required %h",
                     {a_valid, a_redirect, a_pc_out}, {1'b0, 1'b0, 8'd40});
        end
        tick();
        checks++;
        if ({a_valid, a_inst_pc, a_inst_out, a_pc_out} !== {1'b1, 8'd40, 9'd0, 8'd41}) begin
            errors++;
            $display("FAIL jmp_target: {valid,inst_pc,inst_out,pc_out}=%h required %h",
                     {a_valid, a_inst_pc, a_inst_out, a_pc_out}, {1'b1, 8'd40, 9'd0, 8'd41});
        end
    endtask

    // JMP to 252, run up to 255 (default END_PC); fetch address wraps to 0.
    task automatic test_end_wrap();
        tick();
        checks++;
        if ({a_valid, a_redirect, a_inst_pc} !== {1'b1, 1'b1, 8'd41}) begin
            errors++;
            $display("FAIL wrap_jmp: {valid,redirect,inst_pc}=%h required %h",
                     {a_valid, a_redirect, a_inst_pc}, {1'b1, 1'b1, 8'd41});
        end
        wait_a(8'd255);
        checks++;
        if (a_pc_out !== 8'd0) begin
            errors++;
            $display("FAIL wrap_pc_out: pc_out=%0d required 0", a_pc_out);
        end
        tick();
        checks++;
        if ({a_done, a_valid, a_pc_out} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL wrap_done: {done,valid,pc_out}=%h required %h",
                     {a_done, a_valid, a_pc_out}, {1'b1, 1'b0, 8'd0});
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        #1;
        checks++;
        if ({a_done, a_valid, a_pc_out} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL wrap_restart_idle: {done,valid,pc_out}=%h required %h",
                     {a_done, a_valid, a_pc_out}, {1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_brc_taken();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_flag  = 1'b1;
        wait_a(8'd16);
        checks++;
        if (a_redirect !== 1'b1) begin
            errors++;
            $display("FAIL brc_t_redirect: redirect=%b required 1", a_redirect);
        end
        tick();
        checks++;
        if ({a_valid, a_redirect, a_pc_out} !== {1'b0, 1'b0, 8'd18}) begin
            errors++;
            $display("FAIL brc_t_bubble: {valid,redirect,pc_out}=%h required %h",
                     {a_valid, a_redirect, a_pc_out}, {1'b0, 1'b0, 8'd18});
        end
        tick();
        checks++;
        if ({a_valid, a_inst_pc, a_inst_out} !== {1'b1, 8'd18, 9'h089}) begin
            errors++;
            $display("FAIL brc_t_target: {valid,inst_pc,inst_out}=%h required %h",
                     {a_valid, a_inst_pc, a_inst_out}, {1'b1, 8'd18, 9'h089});
        end
        a_flag = 1'b0;
    endtask

    // ---------------------------------------------------------------- B tests
    task automatic test_end_pc();
        b_reset = 1'b1; b_start = 1'b0; b_stall = 1'b0; b_flag = 1'b0;
        tick();
        b_reset = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_b(B_END);
        checks++;
        if ({b_redirect, b_inst_out} !== {1'b0, 9'h1C1}) begin
            errors++;
            $display("FAIL end_jmp_ignored: {redirect,inst_out}=%h required %h",
                     {b_redirect, b_inst_out}, {1'b0, 9'h1C1});
        end
        tick();
        checks++;
        if ({b_done, b_valid, b_redirect} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL end_done: {done,valid,redirect}=%h required %h",
                     {b_done, b_valid, b_redirect}, {1'b1, 1'b0, 1'b0});
        end
        b_stall = 1'b1;
        tick();
        checks++;
        if ({b_done, b_valid, b_pc_out} !== {1'b1, 1'b0, 8'd13}) begin
            errors++;
            $display("FAIL end_hold: {done,valid,pc_out}=%h required %h",
                     {b_done, b_valid, b_pc_out}, {1'b1, 1'b0, 8'd13});
        end
        b_stall = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        #1;
        checks++;
        if ({b_done, b_valid, b_pc_out} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL end_to_idle: {done,valid,pc_out}=%h required %h",
                     {b_done, b_valid, b_pc_out}, {1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_reset_mid_run();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_b(8'd8);
        b_reset = 1'b1;
        b_stall = 1'b1;
        #1;
        checks++;
        if ({b_valid, b_redirect, b_done, b_pc_out} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL midrun_reset_during: {valid,redirect,done,pc_out}=%h required %h",
                     {b_valid, b_redirect, b_done, b_pc_out}, {1'b0, 1'b0, 1'b0, 8'd0});
        end
        tick();
        b_reset = 1'b0;
        b_stall = 1'b0;
        #1;
        checks++;
        if ({b_valid, b_done, b_pc_out, b_inst_pc} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL midrun_reset_after: {valid,done,pc_out,inst_pc}=%h required %h",
                     {b_valid, b_done, b_pc_out, b_inst_pc}, {1'b0, 1'b0, 8'd0, 8'd0});
        end
    endtask

    // Random program + random stall/flag/start against an ISA-level model:
    // the issued stream is pc, pc+1, ... except a taken branch costs one
    // empty slot and continues at its target; issuing END finishes the run.
    task automatic test_random();
        int unsigned r;
        bit   m_idle, m_issuing, m_bubble, m_finished;
        int   m_pc, m_next, tgt;
        bit   taken, is_jmp, is_brc;
        logic [8:0] word;
        int   exp_pc_out;

        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      mem_b[i] = {3'b111, 6'($urandom_range(0, 3))};
            else if (r <= 2) mem_b[i] = {6'b010101, 3'($urandom)};
            else             mem_b[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
        end

        b_reset = 1'b1; b_start = 1'b0; b_stall = 1'b0; b_flag = 1'b0;
        tick();
        b_reset = 1'b0;
        m_idle = 1; m_issuing = 0; m_bubble = 0; m_finished = 0;
        m_pc = 0; m_next = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            b_stall = ($urandom_range(0, 3) == 0);
            b_flag  = 1'($urandom);
            b_start = ($urandom_range(0, 4) == 0);
            #1;
            word   = mem_b[m_pc];
            is_jmp = (word[8:6] == 3'b111);
            is_brc = (word[8:3] == 6'b010101);
            tgt    = is_jmp ? int'(word[5:0]) * 4 : (m_pc + 1 + int'(word[2:0])) % 256;
            taken  = m_issuing && !b_stall && (m_pc != int'(B_END)) && (is_jmp || (is_brc && b_flag));
            exp_pc_out = (m_issuing && b_stall) ? m_pc : m_next;

            checks++;
            if ({b_valid, b_done, b_redirect, b_pc_out} !==
                {m_issuing, m_finished, taken, 8'(exp_pc_out)}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: {valid,done,redirect,pc_out}=%h required %h", cyc,
                         {b_valid, b_done, b_redirect, b_pc_out},
                         {m_issuing, m_finished, taken, 8'(exp_pc_out)});
            end
            if (m_issuing) begin
                checks++;
                if ({b_inst_pc, b_inst_out} !== {8'(m_pc), word}) begin
                    errors++;
                    $display("FAIL rand_issue cyc %0d: {inst_pc,inst_out}=%h required %h", cyc,
                             {b_inst_pc, b_inst_out}, {8'(m_pc), word});
                end
            end

            if (m_idle) begin
                if (b_start) begin
                    m_idle = 0; m_issuing = 1; m_pc = 0; m_next = 1;
                end
            end else if (m_bubble) begin
                m_bubble = 0; m_issuing = 1; m_pc = m_next; m_next = (m_next + 1) % 256;
            end else if (m_issuing) begin
                if (!b_stall) begin
                    if (m_pc == int'(B_END)) begin
                        m_issuing = 0; m_finished = 1;
                    end else if (taken) begin
                        m_issuing = 0; m_bubble = 1; m_next = tgt;
                    end else begin
                        m_pc = m_next; m_next = (m_next + 1) % 256;
                    end
                end
            end else if (m_finished) begin
                if (b_start) begin
                    m_finished = 0; m_idle = 1; m_next = 0;
                end
            end
            tick();
        end
        b_start = 1'b0;
        b_stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 9'd0;
            mem_b[i] = 9'd0;
        end
        mem_a[0]  = 9'b010010_011;
        mem_a[5]  = 9'b010111_001;
        mem_a[16] = 9'b010101_001;   // BRC +1 -> 18
        mem_a[18] = 9'b010001_001;
        mem_a[19] = 9'b111_001010;   // JMP -> 40
        mem_a[41] = 9'b111_111111;   // JMP -> 252
        mem_b[12] = 9'b111_000001;   // JMP at END_PC, must not be taken

        test_reset();
        test_sequential();
        test_stall();
        test_brc_not_taken();
        test_jmp();
        test_end_wrap();
        test_brc_taken();
        test_end_pc();
        test_reset_mid_run();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
